// File: rtl/apb_regbank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_regbank : APB3 slave bank of REGN registers, RO/RW, HW load, wait states
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_regbank #(
  parameter int unsigned       DWIDTH      = 8,
  parameter int unsigned       REGN        = 5,
  parameter int unsigned       AWIDTH      = 3,
  parameter logic [REGN-1:0]   RO_MASK     = '0,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DWIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [AWIDTH-1:0]      PADDR,
  input  logic [DWIDTH-1:0]      PWDATA,
  output logic [DWIDTH-1:0]      PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic [REGN*DWIDTH-1:0] regw_in,
  input  logic [REGN-1:0]        regw_ld,
  output logic [REGN*DWIDTH-1:0] regw_out,
  output logic [REGN-1:0]        regw_we
);

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] addr_q;
  logic              write_q;
  logic [3:0]        wcnt;

  logic [REGN-1:0]   hit;
  logic [DWIDTH-1:0] rd_val;
  logic              in_range;
  logic              err;
  logic              ready;
  logic              commit;

  // hit decodes the captured index; rd_val decodes the live setup-phase index
  always_comb begin
    hit    = '0;
    rd_val = '0;
    for (int i = 0; i < int'(REGN); i++) begin
      hit[i] = (addr_q == AWIDTH'(i));
      if (PADDR == AWIDTH'(i)) rd_val = regw_out[i*DWIDTH +: DWIDTH];
    end
  end

  assign in_range = |hit;
  assign err      = ~in_range | (write_q & |(hit & RO_MASK));
  assign ready    = (state == ACCESS) & PSEL & PENABLE & (wcnt == WAIT_LIMIT);
  assign commit   = ready & write_q & ~err;
  assign PREADY   = ready;
  assign PSLVERR  = ready & err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wcnt    <= '0;
      PRDATA  <= '0;
      regw_we <= '0;
    end else begin
      regw_we <= commit ? hit : '0;
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state   <= ACCESS;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wcnt    <= '0;
            if (!PWRITE) PRDATA <= rd_val;
          end
        end
        ACCESS: begin
          if (!PSEL || ready) begin
            state <= IDLE;
          end else if (wcnt != WAIT_LIMIT) begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(REGN); g++) begin : g_reg
    logic [DWIDTH-1:0] r;

    // APB commit has priority over a same-edge hardware load
    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        r <= RESET_VAL;
      end else if (commit && hit[g]) begin
        r <= PWDATA;
      end else if (regw_ld[g]) begin
        r <= regw_in[g*DWIDTH +: DWIDTH];
      end
    end

    assign regw_out[g*DWIDTH +: DWIDTH] = r;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank.sv
`default_nettype none
// tb_apb_regbank : three bank instances (W=0 with RO reg 1, W=3, W=2),
// vector table plus scoreboard-checked APB transfers.
module tb_apb_regbank;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [2:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];
  logic [39:0] regw_in  [3];
  logic [4:0]  regw_ld  [3];
  logic [39:0] regw_out [3];
  logic [4:0]  regw_we  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    localparam int RO = (g == 0) ? 2 : 0;
    apb_regbank #(
      .DWIDTH(8), .REGN(5), .AWIDTH(3), .RO_MASK(RO),
      .WAIT_STATES(W), .RESET_VAL(8'h00)
    ) u_dut (
      .PCLK(clk), .PRESET(rst),
      .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
      .PADDR(paddr[g]), .PWDATA(pwdata[g]), .PRDATA(prdata[g]),
      .PREADY(pready[g]), .PSLVERR(pslverr[g]),
      .regw_in(regw_in[g]), .regw_ld(regw_ld[g]),
      .regw_out(regw_out[g]), .regw_we(regw_we[g])
    );
  end

  typedef struct {
    bit         wr;
    logic [2:0] a;
    logic [7:0] d;
    bit         err;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] rd;
    bit         wr;
    int         waits;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mdl [3][5];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic int waits_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic logic [39:0] packm(int k);
    logic [39:0] p;
    for (int i = 0; i < 5; i++) p[i*8 +: 8] = mdl[k][i];
    return p;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input int k, input bit wr, input logic [2:0] a,
                      input logic [7:0] d, input bit exp_err,
                      input logic [7:0] exp_rd, input logic [4:0] ld_mask,
                      input logic [7:0] ld_data);
    exp_t       e;
    exp_t       got;
    int         waits;
    bit         seen;
    logic [4:0] we_exp;
    e.err = exp_err; e.rd = exp_rd; e.wr = wr; e.waits = waits_of(k);
    sb.push_back(e);
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    waits = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (pready[k]) seen = 1'b1;
      else begin
        waits++;
        check("pslverr_during_wait", pslverr[k], 1'b0);
      end
    end
    got = sb.pop_front();
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL pready_timeout: inst %0d got no PREADY, expected one", k);
      @(posedge clk); #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
      return;
    end
    check("wait_cycles", waits, got.waits);
    check("pslverr", pslverr[k], got.err);
    if (!got.wr) check("prdata", prdata[k], got.rd);
    check("regw_out_precommit", regw_out[k], packm(k));
    regw_ld[k] = ld_mask;
    for (int i = 0; i < 5; i++)
      if (ld_mask[i]) begin
        regw_in[k][i*8 +: 8] = ld_data;
        mdl[k][i] = ld_data;
      end
    if (wr && !exp_err && a < 3'd5) mdl[k][a] = d;
    we_exp = (wr && !exp_err) ? (5'd1 << a) : 5'd0;
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0; regw_ld[k] = '0;
    @(negedge clk);
    check("regw_we_pulse", regw_we[k], we_exp);
    check("regw_out", regw_out[k], packm(k));
    check("pready_after", pready[k], 1'b0);
    @(negedge clk);
    check("regw_we_clear", regw_we[k], 5'd0);
  endtask

  vec_t tbl [12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1'b1, 3'd2, 8'hA5, 1'b0, 8'h00},
      '{1'b0, 3'd2, 8'h00, 1'b0, 8'hA5},
      '{1'b1, 3'd1, 8'hFF, 1'b1, 8'h00},
      '{1'b0, 3'd1, 8'h00, 1'b0, 8'h3C},
      '{1'b0, 3'd6, 8'h00, 1'b1, 8'h00},
      '{1'b1, 3'd7, 8'h55, 1'b1, 8'h00},
      '{1'b1, 3'd4, 8'h99, 1'b0, 8'h00},
      '{1'b0, 3'd4, 8'h00, 1'b0, 8'h99},
      '{1'b0, 3'd0, 8'h00, 1'b0, 8'h00},
      '{1'b1, 3'd0, 8'h12, 1'b0, 8'h00},
      '{1'b0, 3'd0, 8'h00, 1'b0, 8'h12},
      '{1'b0, 3'd3, 8'h00, 1'b0, 8'h00}
    };
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = '0; pwdata[k] = '0;
      regw_in[k] = '0; regw_ld[k] = '0;
      for (int i = 0; i < 5; i++) mdl[k][i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pready", pready[0], 1'b0);
    check("reset_pslverr", pslverr[0], 1'b0);
    check("reset_prdata", prdata[0], 8'h00);
    check("reset_regw_out", regw_out[0], 40'h0);
    check("reset_regw_we", regw_we[0], 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // PENABLE high while IDLE must not start a transfer
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 3'd0; pwdata[0] = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_penable_pready", pready[0], 1'b0);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("idle_penable_no_write", regw_out[0], packm(0));

    // hardware load into read-only register 1
    @(posedge clk); #1;
    regw_ld[0] = 5'b00010; regw_in[0][15:8] = 8'h3C;
    @(posedge clk); #1;
    regw_ld[0] = '0;
    mdl[0][1] = 8'h3C;
    @(negedge clk);
    check("hw_load_ro", regw_out[0], packm(0));

    foreach (tbl[i])
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].err, tbl[i].rd, 5'd0, 8'h00);

    // same-edge hardware load and APB commit to register 3
    xfer(0, 1'b1, 3'd3, 8'h77, 1'b0, 8'h00, 5'b01000, 8'h22);
    check("same_edge_apb_wins", regw_out[0][31:24], 8'h77);

    // WAIT_STATES = 3 instance
    xfer(1, 1'b1, 3'd0, 8'h11, 1'b0, 8'h00, 5'd0, 8'h00);
    xfer(1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h11, 5'd0, 8'h00);

    // PSEL dropped during ACCESS aborts the write
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 3'd2; pwdata[1] = 8'h44;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    check("abort_pready_low", pready[1], 1'b0);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check("abort_no_we", regw_we[1], 5'd0);
    @(negedge clk);
    check("abort_no_write", regw_out[1], packm(1));
    xfer(1, 1'b0, 3'd2, 8'h00, 1'b0, 8'h00, 5'd0, 8'h00);

    // reset in the middle of a WAIT_STATES = 2 write
    xfer(2, 1'b1, 3'd0, 8'h5A, 1'b0, 8'h00, 5'd0, 8'h00);
    xfer(2, 1'b0, 3'd0, 8'h00, 1'b0, 8'h5A, 5'd0, 8'h00);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 3'd1; pwdata[2] = 8'h66;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("midreset_pre_pready", pready[2], 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 5; i++) mdl[k][i] = 8'h00;
    check("midreset_pready", pready[2], 1'b0);
    check("midreset_prdata", prdata[2], 8'h00);
    check("midreset_regs", regw_out[2], 40'h0);
    check("midreset_regs_inst0", regw_out[0], 40'h0);
    check("midreset_we", regw_we[2], 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk);
    check("postreset_we", regw_we[2], 5'd0);
    check("postreset_regs", regw_out[2], packm(2));
    xfer(2, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 5'd0, 8'h00);
    xfer(2, 1'b1, 3'd1, 8'h66, 1'b0, 8'h00, 5'd0, 8'h00);
    xfer(2, 1'b0, 3'd1, 8'h00, 1'b0, 8'h66, 5'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
